// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-source bypass selection, RAW/WAW/capacity
// stall generation and busy tracking for outstanding long-latency producers.
module hazard_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NSRC     = 2,
    parameter int NSTAGE   = 3,
    parameter int MAX_LONG = 4,
    localparam int AW      = $clog2(NREG),
    localparam int CW      = $clog2(MAX_LONG + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dec_valid,
    input  logic [NSRC*AW-1:0]     dec_rs,
    input  logic [NSRC-1:0]        dec_rs_used,
    input  logic [AW-1:0]          dec_rd,
    input  logic                   dec_rd_we,
    input  logic                   dec_long,
    input  logic                   issue_ready,
    input  logic [NSTAGE-1:0]      stg_valid,
    input  logic [NSTAGE-1:0]      stg_we,
    input  logic [NSTAGE-1:0]      stg_data_ok,
    input  logic [NSTAGE*AW-1:0]   stg_rd,
    input  logic [NSTAGE*XLEN-1:0] stg_data,
    input  logic                   lwb_valid,
    input  logic [AW-1:0]          lwb_rd,
    input  logic [XLEN-1:0]        lwb_data,
    output logic                   stall_D,
    output logic [NSRC-1:0]        fwd_valid,
    output logic [NSRC*XLEN-1:0]   fwd_data,
    output logic [CW-1:0]          long_cnt,
    output logic [31:0]            stall_cnt,
    output logic                   sb_err
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   long_cnt_q, long_cnt_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic            sb_err_q, sb_err_d;

    logic raw_stall;
    logic waw_stall;
    logic cap_stall;
    logic issue;
    logic set_en;
    logic clr_en;

    // The youngest matching stage shadows older ones and the long-op writeback.
    always_comb begin : bypass_select
        logic hit;
        hit       = 1'b0;
        raw_stall = 1'b0;
        fwd_valid = '0;
        fwd_data  = '0;
        for (int s = 0; s < NSRC; s++) begin
            hit = 1'b0;
            if (dec_rs_used[s] && (dec_rs[s*AW +: AW] != '0)) begin
                for (int t = 0; t < NSTAGE; t++) begin
                    if (!hit && stg_valid[t] && stg_we[t] &&
                        (stg_rd[t*AW +: AW] == dec_rs[s*AW +: AW])) begin
                        hit = 1'b1;
                        if (stg_data_ok[t]) begin
                            fwd_valid[s]                = 1'b1;
                            fwd_data[s*XLEN +: XLEN]    = stg_data[t*XLEN +: XLEN];
                        end else begin
                            raw_stall = 1'b1;
                        end
                    end
                end
                if (!hit) begin
                    if (lwb_valid && (lwb_rd == dec_rs[s*AW +: AW])) begin
                        fwd_valid[s]             = 1'b1;
                        fwd_data[s*XLEN +: XLEN] = lwb_data;
                    end else if (busy_q[dec_rs[s*AW +: AW]]) begin
                        raw_stall = 1'b1;
                    end
                end
            end
        end
    end

    // WAW and capacity look only at registered state, so a same-cycle lwb never unblocks them.
    always_comb begin
        waw_stall = dec_rd_we && (dec_rd != '0) && busy_q[dec_rd];
        cap_stall = dec_long && (long_cnt_q == CW'(MAX_LONG));
        stall_D   = dec_valid && (raw_stall || waw_stall || cap_stall);
        issue     = dec_valid && issue_ready && !stall_D;
        set_en    = issue && dec_long && dec_rd_we && (dec_rd != '0);
        clr_en    = lwb_valid && busy_q[lwb_rd];
    end

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[lwb_rd] = 1'b0;
        end
        if (set_en) begin
            busy_d[dec_rd] = 1'b1;
        end

        long_cnt_d = long_cnt_q;
        if (set_en && !clr_en) begin
            long_cnt_d = long_cnt_q + CW'(1);
        end else if (clr_en && !set_en) begin
            long_cnt_d = long_cnt_q - CW'(1);
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_D && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end

        sb_err_d = sb_err_q || (lwb_valid && !busy_q[lwb_rd]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            long_cnt_q  <= '0;
            stall_cnt_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            long_cnt_q  <= long_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign long_cnt  = long_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign sb_err    = sb_err_q;

endmodule
